// File: rtl/localization_pkg.sv
// Shared types and constants for the localization chain: direction bins,
// the heading tracker state encoding and servo timing constants.
package localization_pkg;

  localparam int NUM_BINS = 16;

  typedef logic [3:0] bin_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UPDATE = 2'd1,
    SCAN   = 2'd2,
    DECIDE = 2'd3
  } trk_state_e;

  localparam int SERVO_FRAME_HZ = 50;
  localparam int SERVO_MIN_US   = 1000;
  localparam int SERVO_SPAN_US  = 1000;

endpackage

// File: rtl/servo_pwm_gen.sv
// Hobby-servo PWM generator: 50 Hz frame, pulse width 1 ms + heading/16 ms.
// The pulse width is latched once per frame so a heading change never
// produces a truncated or stretched pulse. Used only when the build
// defines HEADING_TRACKER_SERVO_EN.
module servo_pwm_gen
  import localization_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  bin_t heading_i,
  output logic pwm_o
);

  localparam int FRAME_CYC = CLK_FREQ_HZ / SERVO_FRAME_HZ;
  localparam int MIN_CYC   = CLK_FREQ_HZ / (1_000_000 / SERVO_MIN_US);
  localparam int SPAN_CYC  = CLK_FREQ_HZ / (1_000_000 / SERVO_SPAN_US);
  localparam int FW        = $clog2(FRAME_CYC);
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_CYC - 1);

  logic [FW-1:0] frame_q;
  logic [FW-1:0] width_q;
  logic          pwm_q;
  logic [31:0]   width_full;

  // heading/16 of the span; the multiply happens before the shift to keep precision
  assign width_full = 32'(MIN_CYC) + ((32'(heading_i) * 32'(SPAN_CYC)) >> 4);

  // Frame counter, per-frame width latch and pulse register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      frame_q <= '0;
      width_q <= '0;
      pwm_q   <= 1'b0;
    end else begin
      if (frame_q == FRAME_LAST) begin
        frame_q <= '0;
        width_q <= FW'(width_full);
      end else begin
        frame_q <= frame_q + FW'(1);
      end
      pwm_q <= en_i && (frame_q < width_q);
    end
  end

  // Gate with enable so the output drops in the same cycle the heading is invalidated
  assign pwm_o = pwm_q & en_i;

endmodule

// File: rtl/heading_tracker.sv
// Heading tracker: keeps a ring of the most recent direction bins and a
// per-bin histogram, runs a sequential argmax after every accepted bin and
// publishes a heading only once a bin reaches a majority. A previously
// published heading persists below majority (hysteresis).
// Optional build macro: HEADING_TRACKER_SERVO_EN adds servo_pwm_out.
module heading_tracker
  import localization_pkg::*;
#(
  parameter int HISTORY_DEPTH = 8,
  parameter int MAJORITY      = 5,
  parameter int CLK_FREQ_HZ   = 100_000_000
) (
  input  logic                             clk_in,
  input  logic                             rst_in,
  input  logic [4:0]                       bin_in,
  input  logic                             bin_valid_in,
  output logic                             bin_ready_out,
  input  logic                             clear_in,
  output logic [3:0]                       heading_out,
  output logic                             heading_valid_out,
  output logic                             heading_changed_out,
  output logic [$clog2(HISTORY_DEPTH+1)-1:0] confidence_out,
  output logic                             bin_error_out
`ifdef HEADING_TRACKER_SERVO_EN
  ,
  output logic                             servo_pwm_out
`endif
);

  localparam int CW = $clog2(HISTORY_DEPTH + 1);
  localparam int PW = (HISTORY_DEPTH > 1) ? $clog2(HISTORY_DEPTH) : 1;
  localparam logic [PW-1:0] PTR_LAST = PW'(HISTORY_DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(HISTORY_DEPTH);
  localparam logic [CW-1:0] MAJ_CNT  = CW'(MAJORITY);

  trk_state_e    state_q, state_d;
  logic          ready_q;
  logic [4:0]    bin_q;
  bin_t          hist_q [HISTORY_DEPTH];
  logic [CW-1:0] cnt_q  [NUM_BINS];
  logic [CW-1:0] cnt_d  [NUM_BINS];
  logic [CW-1:0] fill_q;
  logic [PW-1:0] wptr_q;
  bin_t          scan_q;
  logic [CW-1:0] max_q;
  bin_t          idx_q;
  bin_t          heading_q;
  logic          hvalid_q;
  logic          changed_q;
  logic [CW-1:0] conf_q;
  logic          err_q;
  logic          hist_full;

  assign hist_full = (fill_q == FULL_CNT);

  // State register
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; clear overrides everything
  always_comb begin
    state_d = state_q;
    if (clear_in) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (bin_valid_in && ready_q) state_d = UPDATE;
        UPDATE:  state_d = bin_q[4] ? IDLE : SCAN;
        SCAN:    if (scan_q == 4'hF) state_d = DECIDE;
        DECIDE:  state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Histogram update: add the new bin and, once full, retire the evicted one
  always_comb begin
    for (int b = 0; b < NUM_BINS; b++) begin
      cnt_d[b] = cnt_q[b];
    end
    if (state_q == UPDATE && !bin_q[4]) begin
      for (int b = 0; b < NUM_BINS; b++) begin
        cnt_d[b] = cnt_q[b]
                 + CW'(bin_q[3:0] == bin_t'(b))
                 - CW'(hist_full && (hist_q[wptr_q] == bin_t'(b)));
      end
    end
  end

  // Datapath and output registers for handshake, history, scan and decision
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      ready_q   <= 1'b0;
      bin_q     <= '0;
      fill_q    <= '0;
      wptr_q    <= '0;
      scan_q    <= '0;
      max_q     <= '0;
      idx_q     <= '0;
      heading_q <= '0;
      hvalid_q  <= 1'b0;
      changed_q <= 1'b0;
      conf_q    <= '0;
      err_q     <= 1'b0;
      for (int i = 0; i < HISTORY_DEPTH; i++) hist_q[i] <= '0;
      for (int b = 0; b < NUM_BINS; b++)      cnt_q[b]  <= '0;
    end else if (clear_in) begin
      ready_q   <= 1'b1;
      fill_q    <= '0;
      wptr_q    <= '0;
      hvalid_q  <= 1'b0;
      changed_q <= 1'b0;
      conf_q    <= '0;
      err_q     <= 1'b0;
      for (int i = 0; i < HISTORY_DEPTH; i++) hist_q[i] <= '0;
      for (int b = 0; b < NUM_BINS; b++)      cnt_q[b]  <= '0;
    end else begin
      changed_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bin_valid_in && ready_q) begin
            bin_q   <= bin_in;
            ready_q <= 1'b0;
          end else begin
            ready_q <= 1'b1;
          end
        end
        UPDATE: begin
          if (bin_q[4]) begin
            err_q   <= 1'b1;
            ready_q <= 1'b1;
          end else begin
            hist_q[wptr_q] <= bin_q[3:0];
            wptr_q <= (wptr_q == PTR_LAST) ? '0 : wptr_q + PW'(1);
            if (!hist_full) fill_q <= fill_q + CW'(1);
            cnt_q  <= cnt_d;
            scan_q <= '0;
            max_q  <= '0;
            idx_q  <= '0;
          end
        end
        SCAN: begin
          // strict compare keeps the lowest index on ties
          if (cnt_q[scan_q] > max_q) begin
            max_q <= cnt_q[scan_q];
            idx_q <= scan_q;
          end
          scan_q <= scan_q + 4'd1;
        end
        DECIDE: begin
          conf_q <= max_q;
          if (max_q >= MAJ_CNT && (!hvalid_q || idx_q != heading_q)) begin
            heading_q <= idx_q;
            hvalid_q  <= 1'b1;
            changed_q <= 1'b1;
          end
          ready_q <= 1'b1;
        end
        default: ready_q <= 1'b0;
      endcase
    end
  end

  assign bin_ready_out       = ready_q & ~clear_in;
  assign heading_out         = heading_q;
  assign heading_valid_out   = hvalid_q;
  assign heading_changed_out = changed_q;
  assign confidence_out      = conf_q;
  assign bin_error_out       = err_q;

`ifdef HEADING_TRACKER_SERVO_EN
  servo_pwm_gen #(
    .CLK_FREQ_HZ (CLK_FREQ_HZ)
  ) u_servo (
    .clk_i     (clk_in),
    .rst_i     (rst_in),
    .en_i      (hvalid_q),
    .heading_i (heading_q),
    .pwm_o     (servo_pwm_out)
  );
`endif

endmodule

// File: tb/tb_heading_tracker.sv
// Scoreboard bench for heading_tracker (default parameters: depth 8, majority 5).
// Every rising edge of bin_ready_out marks the end of a transaction (reset
// release, decision, error discard or clear); the monitor pops the expected
// outputs for that event and compares them.
module tb_heading_tracker;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] bin;
  logic       bin_valid;
  logic       bin_ready;
  logic       clear;
  logic [3:0] heading;
  logic       heading_valid;
  logic       heading_changed;
  logic [3:0] confidence;
  logic       bin_error;

  always #5 clk = ~clk;

  heading_tracker dut (
    .clk_in              (clk),
    .rst_in              (rst),
    .bin_in              (bin),
    .bin_valid_in        (bin_valid),
    .bin_ready_out       (bin_ready),
    .clear_in            (clear),
    .heading_out         (heading),
    .heading_valid_out   (heading_valid),
    .heading_changed_out (heading_changed),
    .confidence_out      (confidence),
    .bin_error_out       (bin_error)
  );

  typedef struct {
    int heading;
    int hvalid;
    int changed;
    int conf;
    int err;
    int lat;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   hs_cyc   = 0;
  logic prev_ready = 1'b0;
  logic chk_fall   = 1'b0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic expect_ev(input int h, input int hv, input int ch,
                           input int cf, input int er, input int lat);
    exp_t e;
    e.heading = h; e.hvalid = hv; e.changed = ch;
    e.conf = cf; e.err = er; e.lat = lat;
    q.push_back(e);
  endtask

  always @(posedge clk) cyc++;

  // Monitor: event processing first, then handshake bookkeeping
  always @(negedge clk) begin
    if (chk_fall) begin
      check("changed_pulse_width", int'(heading_changed), 0);
      chk_fall = 1'b0;
    end
    if (bin_ready && !prev_ready) begin
      if (q.size() == 0) begin
        check("unexpected_event", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("heading", int'(heading), e.heading);
        check("heading_valid", int'(heading_valid), e.hvalid);
        check("heading_changed", int'(heading_changed), e.changed);
        check("confidence", int'(confidence), e.conf);
        check("bin_error", int'(bin_error), e.err);
        if (e.lat >= 0) check("latency", cyc - hs_cyc, e.lat);
        if (e.changed != 0) chk_fall = 1'b1;
      end
    end
    if (bin_valid && bin_ready) hs_cyc = cyc + 1;
    prev_ready = bin_ready;
  end

  task automatic send_bin(input logic [4:0] b);
    bit done;
    done = 1'b0;
    @(posedge clk); #1;
    bin_valid = 1'b1;
    bin = b;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (bin_ready) done = 1'b1;
    end
    if (!done) check("handshake_timeout", 0, 1);
    @(posedge clk); #1;
    bin_valid = 1'b0;
  endtask

  task automatic wait_ready();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (bin_ready) done = 1'b1;
    end
    if (!done) check("ready_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // Hand-computed decision tables
  int c11 [8]  = '{7, 6, 5, 4, 5, 6, 7, 8};
  int h11 [8]  = '{3, 3, 3, 3, 11, 11, 11, 11};
  int ch11[8]  = '{0, 0, 0, 0, 1, 0, 0, 0};
  int calt[16] = '{1, 1, 2, 2, 3, 3, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4};

  initial begin
    rst = 1'b1; bin = '0; bin_valid = 1'b0; clear = 1'b0;
    expect_ev(0, 0, 0, 0, 0, -1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // five 3s from empty: heading appears on the fifth
    for (int i = 1; i <= 5; i++) begin
      if (i < 5) expect_ev(0, 0, 0, i, 0, 18);
      else       expect_ev(3, 1, 1, 5, 0, 18);
      send_bin(5'd3);
    end
    // fill the history with 3s
    for (int i = 6; i <= 8; i++) begin
      expect_ev(3, 1, 0, i, 0, 18);
      send_bin(5'd3);
    end
    // eight 11s displace the 3s; switch on the fifth
    for (int k = 0; k < 8; k++) begin
      expect_ev(h11[k], 1, ch11[k], c11[k], 0, 18);
      send_bin(5'd11);
    end
    // illegal bin: discarded, sticky error, histogram untouched
    expect_ev(11, 1, 0, 8, 1, 1);
    send_bin(5'h13);
    expect_ev(11, 1, 0, 8, 1, 18);
    send_bin(5'd11);

    // clear together with a valid bin in IDLE: no handshake, heading kept
    expect_ev(11, 0, 0, 0, 0, -1);
    wait_ready();
    @(posedge clk); #1;
    clear = 1'b1; bin_valid = 1'b1; bin = 5'd2;
    @(posedge clk); #1;
    clear = 1'b0; bin_valid = 1'b0;

    // alternating 2/6 never reaches majority
    for (int i = 0; i < 16; i++) begin
      expect_ev(11, 0, 0, calt[i], 0, 18);
      send_bin((i % 2 == 0) ? 5'd2 : 5'd6);
    end

    // clear during SCAN aborts the pending decision and empties the counts
    send_bin(5'd9);
    expect_ev(11, 0, 0, 0, 0, -1);
    repeat (5) @(posedge clk);
    #1 clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      if (i < 5) expect_ev(11, 0, 0, i, 0, 18);
      else       expect_ev(9, 1, 1, 5, 0, 18);
      send_bin(5'd9);
    end

    // reset in the middle of a scan: everything returns to zero
    send_bin(5'd4);
    expect_ev(0, 0, 0, 0, 0, -1);
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 100 && q.size() != 0; i++) @(posedge clk);
    repeat (30) @(posedge clk);
    check("queue_drained", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
